// File: rtl/rsa_io_pkg.sv
// Shared types and constants for the RSA operand/result byte I/O path.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: serializer state encoding, default header byte, bytes_of() helper.
package rsa_io_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } ser_state_t;

    localparam logic [7:0] HDR_BYTE_DFLT = 8'hA5;

    function automatic int bytes_of(input int n);
        return n / 8;
    endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// Word holding register that exposes one end byte and shifts it out 8 bits at a time.
// Latency: load/shift take effect at the next clock edge; cur_byte is combinational from the register.
// Backpressure: none; the owner decides when to load and when to shift.
// Ports: clk, rst (sync, active-high), load + data (capture word), shift (drop consumed byte),
//        cur_byte (byte at the consumed end: MSB end if MSB_FIRST, else LSB end).
module byte_shift_reg #(
    parameter int N         = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] data,
    output logic [7:0]   cur_byte
);

    logic [N-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            // Shift toward the end just consumed so the next byte lands in its place.
            sr <= MSB_FIRST ? (sr << 8) : (sr >> 8);
        end
    end

    assign cur_byte = MSB_FIRST ? sr[N-1 -: 8] : sr[7:0];

endmodule

// File: rtl/word_serializer.sv
// Serialises one N-bit word into N/8 UART frames, one byte per frame, interlocked on the UART busy flag.
// Latency: accept -> first tx_valid is 2 cycles with the UART idle; word_done follows the last frame's end.
// Backpressure: in_ready is low from the cycle after acceptance until the cycle after word_done.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data word input; is_transmitting UART busy;
//        tx_byte/tx_valid byte + start strobe to the UART; word_done completion pulse.
// Build option: define WORD_SERIALIZER_HDR_EN to prefix every word with HDR_BYTE.
module word_serializer
    import rsa_io_pkg::*;
#(
    parameter int         N         = 16,
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DFLT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         is_transmitting,
    output logic [7:0]   tx_byte,
    output logic         tx_valid,
    output logic         word_done
);

    localparam int NBYTES = bytes_of(N);
`ifdef WORD_SERIALIZER_HDR_EN
    localparam int NFRAMES = NBYTES + 1;
`else
    localparam int NFRAMES = NBYTES;
`endif
    // Sized from the frame count so the extra header frame still fits the counter.
    localparam int             CW       = $clog2(NFRAMES + 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(NFRAMES);

    ser_state_t    state;
    logic [CW-1:0] cnt;
    logic [7:0]    cur_byte;
    logic          hdr_pending;
    logic          sr_load;
    logic          sr_shift;

`ifdef WORD_SERIALIZER_HDR_EN
    // The counter only holds its load value before the header frame has gone out.
    assign hdr_pending = (cnt == CNT_LOAD);
`else
    assign hdr_pending = 1'b0;
`endif

    assign sr_load  = (state == IDLE) && in_ready && in_valid;
    assign sr_shift = (state == LOAD) && !is_transmitting && !hdr_pending;

    byte_shift_reg #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .shift    (sr_shift),
        .data     (in_data),
        .cur_byte (cur_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            tx_valid  <= 1'b0;
            tx_byte   <= 8'h00;
            word_done <= 1'b0;
            cnt       <= '0;
        end else begin
            tx_valid  <= 1'b0;
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    // in_ready is still low during the word_done cycle; raise it one cycle later.
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        in_ready <= 1'b0;
                        cnt      <= CNT_LOAD;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // Captured here so tx_byte carries the pre-shift byte and stays put until the next LOAD.
                    tx_byte <= hdr_pending ? HDR_BYTE : cur_byte;
                    if (!is_transmitting) begin
                        tx_valid <= 1'b1;
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (is_transmitting) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!is_transmitting) begin
                        if (cnt != '0) begin
                            state <= LOAD;
                        end else begin
                            word_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer: two instances (16-bit MSB-first, 32-bit LSB-first), each with a UART model.
// Expected byte streams come from a byte-order model of the word; protocol rules are watched every cycle.
module tb_word_serializer;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst16, rst32;
    logic        in_valid16, in_valid32;
    logic        in_ready16, in_ready32;
    logic [15:0] in_data16;
    logic [31:0] in_data32;
    logic        is_tx16, is_tx32;
    logic [7:0]  tx_byte16, tx_byte32;
    logic        tx_valid16, tx_valid32;
    logic        word_done16, word_done32;

    // UART models and an extra busy source for the shared-UART case.
    logic ext16 = 1'b0, ext32 = 1'b0;
    logic busy16 = 1'b0, busy32 = 1'b0;
    int   ucnt16 = 0, ucnt32 = 0;
    int   frame16 = 10, frame32 = 4;

    // Monitor state.
    bq_t  got16, got32;
    int   done16 = 0, done32 = 0;
    int   viol16 = 0, viol32 = 0;
    logic prev_tv16 = 1'b0, prev_tv32 = 1'b0;

    // Reference expectations.
    bq_t  exp16, exp32;
    int   exp_done16 = 0, exp_done32 = 0;
    int   ptr16 = 0, ptr32 = 0;

    int   checks = 0;
    int   errors = 0;

    assign is_tx16 = busy16 | ext16;
    assign is_tx32 = busy32 | ext32;

    always #5 clk = ~clk;

    word_serializer #(.N(16), .MSB_FIRST(1'b1)) u16 (
        .clk(clk), .rst(rst16), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .is_transmitting(is_tx16), .tx_byte(tx_byte16), .tx_valid(tx_valid16), .word_done(word_done16)
    );

    word_serializer #(.N(32), .MSB_FIRST(1'b0)) u32 (
        .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
        .is_transmitting(is_tx32), .tx_byte(tx_byte32), .tx_valid(tx_valid32), .word_done(word_done32)
    );

    // UART: a strobe while idle starts a frame that keeps busy high for frameNN cycles.
    always @(posedge clk) begin
        if (busy16) begin
            if (ucnt16 <= 1) busy16 <= 1'b0;
            else             ucnt16 <= ucnt16 - 1;
        end else if (tx_valid16) begin
            busy16 <= 1'b1;
            ucnt16 <= frame16;
        end
        if (busy32) begin
            if (ucnt32 <= 1) busy32 <= 1'b0;
            else             ucnt32 <= ucnt32 - 1;
        end else if (tx_valid32) begin
            busy32 <= 1'b1;
            ucnt32 <= frame32;
        end
    end

    // Monitor: capture strobed bytes, count completions, flag protocol violations.
    always @(negedge clk) begin
        if (tx_valid16) got16.push_back(tx_byte16);
        if (word_done16) done16 = done16 + 1;
        if (tx_valid16 && (word_done16 || is_tx16 || prev_tv16)) viol16 = viol16 + 1;
        if (word_done16 && in_ready16) viol16 = viol16 + 1;
        prev_tv16 = tx_valid16;
        if (tx_valid32) got32.push_back(tx_byte32);
        if (word_done32) done32 = done32 + 1;
        if (tx_valid32 && (word_done32 || is_tx32 || prev_tv32)) viol32 = viol32 + 1;
        if (word_done32 && in_ready32) viol32 = viol32 + 1;
        prev_tv32 = tx_valid32;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the word's bytes in wire order, header first when compiled in.
    task automatic model(input bit wide, input logic [31:0] w);
        int nb  = wide ? 4 : 2;
        bit msb = !wide;
        logic [31:0] sh;
`ifdef WORD_SERIALIZER_HDR_EN
        if (wide) exp32.push_back(8'hA5); else exp16.push_back(8'hA5);
`endif
        for (int i = 0; i < nb; i++) begin
            sh = w >> (8 * (msb ? (nb - 1 - i) : i));
            if (wide) exp32.push_back(sh[7:0]); else exp16.push_back(sh[7:0]);
        end
        if (wide) exp_done32++; else exp_done16++;
    endtask

    task automatic send_word(input bit wide, input logic [31:0] w);
        int t = 0;
        if (wide) begin in_valid32 = 1'b1; in_data32 = w; end
        else      begin in_valid16 = 1'b1; in_data16 = w[15:0]; end
        while (!(wide ? in_ready32 : in_ready16) && t < 3000) begin tick(); t++; end
        check("accept_in_time", 32'(t < 3000), 32'd1);
        tick();
        if (wide) in_valid32 = 1'b0; else in_valid16 = 1'b0;
        model(wide, w);
    endtask

    task automatic wait_done(input bit wide, input string tag);
        int t = 0;
        while ((wide ? (done32 < exp_done32) : (done16 < exp_done16)) && t < 3000) begin tick(); t++; end
        check({tag, "_done_count"}, wide ? done32 : done16, wide ? exp_done32 : exp_done16);
    endtask

    task automatic cmp_q(input string tag, input bq_t g, input bq_t e, input int from);
        check({tag, "_byte_count"}, g.size(), e.size());
        for (int i = from; i < e.size() && i < g.size(); i++)
            check({tag, "_byte"}, {24'h0, g[i]}, {24'h0, e[i]});
    endtask

    task automatic cmp(input bit wide, input string tag);
        if (wide) begin cmp_q(tag, got32, exp32, ptr32); ptr32 = exp32.size(); end
        else      begin cmp_q(tag, got16, exp16, ptr16); ptr16 = exp16.size(); end
    endtask

    initial begin
        int t;
        logic [31:0] w;
        bit wide;

        rst16 = 1'b1; rst32 = 1'b1;
        in_valid16 = 1'b0; in_valid32 = 1'b0;
        in_data16 = '0; in_data32 = '0;
        repeat (3) tick();
        // Reset state.
        check("rst_in_ready16", in_ready16, 1);
        check("rst_tx_valid16", tx_valid16, 0);
        check("rst_tx_byte16", tx_byte16, 0);
        check("rst_word_done16", word_done16, 0);
        check("rst_in_ready32", in_ready32, 1);
        check("rst_tx_valid32", tx_valid32, 0);
        rst16 = 1'b0; rst32 = 1'b0;
        tick();

        // Test 1: BEEF, MSB first, 10-cycle frames; in_ready back only after word_done.
        frame16 = 10;
        send_word(0, 32'hBEEF);
        wait_done(0, "t1");
        check("t1_in_ready_in_done_cycle", in_ready16, 0);
        tick();
        check("t1_in_ready_after_done", in_ready16, 1);
        cmp(0, "t1");

        // Test 2: 32-bit LSB first; a stray in_valid mid-word adds nothing.
        frame32 = 6;
        send_word(1, 32'h12345678);
        repeat (5) tick();
        check("t2_in_ready_mid_word", in_ready32, 0);
        in_valid32 = 1'b1; in_data32 = 32'hDEADBEEF;
        tick();
        in_valid32 = 1'b0;
        wait_done(1, "t2");
        repeat (10) tick();
        cmp(1, "t2");
        check("t2_no_extra_done", done32, exp_done32);

        // Test 3: UART busy before acceptance holds the first strobe off.
        frame16 = 3;
        ext16 = 1'b1;
        send_word(0, 32'h0102);
        repeat (20) tick();
        check("t3_no_tx_while_busy", got16.size(), ptr16);
        ext16 = 1'b0;
        wait_done(0, "t3");
        cmp(0, "t3");

        // Test 4: reset during WAIT_DONE of the first byte aborts the word.
        frame16 = 10;
        send_word(0, 32'hAAAA);
        t = 0;
        while (got16.size() == ptr16 && t < 200) begin tick(); t++; end
        while (!busy16 && t < 200) begin tick(); t++; end
        check("t4_first_byte_seen", 32'(t < 200), 32'd1);
        tick();
        rst16 = 1'b1;
        tick();
        rst16 = 1'b0;
        check("t4_in_ready", in_ready16, 1);
        check("t4_tx_valid", tx_valid16, 0);
        check("t4_tx_byte", tx_byte16, 0);
        check("t4_word_done", word_done16, 0);
        void'(exp16.pop_back());
        exp_done16--;
        repeat (30) tick();
        cmp(0, "t4_abort");
        check("t4_no_done", done16, exp_done16);
        send_word(0, 32'h5555);
        wait_done(0, "t4_new");
        cmp(0, "t4_new");

        // Test 5: back-to-back words with in_valid held high.
        frame16 = 4;
        in_valid16 = 1'b1; in_data16 = 16'h1111;
        t = 0;
        while (!in_ready16 && t < 3000) begin tick(); t++; end
        tick();
        model(0, 32'h1111);
        in_data16 = 16'h2222;
        while (!in_ready16 && t < 3000) begin tick(); t++; end
        check("t5_accept_in_time", 32'(t < 3000), 32'd1);
        tick();
        in_valid16 = 1'b0;
        model(0, 32'h2222);
        wait_done(0, "t5");
        cmp(0, "t5");

        // Test 6: C0DE (header prefix when compiled in).
        send_word(0, 32'hC0DE);
        wait_done(0, "t6");
        cmp(0, "t6");

        // Randomised words, frame lengths and idle gaps on both instances.
        for (int k = 0; k < 12; k++) begin
            wide = 1'($urandom_range(0, 1));
            w = $urandom;
            if (wide) frame32 = $urandom_range(1, 6); else frame16 = $urandom_range(1, 6);
            repeat ($urandom_range(0, 3)) tick();
            send_word(wide, w);
            wait_done(wide, "rnd");
            cmp(wide, "rnd");
        end

        repeat (5) tick();
        check("protocol_viol16", viol16, 0);
        check("protocol_viol32", viol32, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
